// File: rtl/maze_job_ctrl.sv
// Job controller for a maze solver: loads the maze row by row, pulses the solver
// reset, supervises the run with step/cycle counting and a timeout, then reports.
module maze_job_ctrl #(
  parameter int SIZE       = 9,
  parameter int MAX_CYCLES = 1023,
  parameter int RST_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    row_valid,
  input  logic [SIZE-1:0]         row_data,
  output logic                    row_ready,
  input  logic                    abort,
  output logic [SIZE*SIZE-1:0]    maze_flat,
  output logic                    solver_rst,
  input  logic                    solver_done,
  input  logic [$clog2(SIZE)-1:0] solver_x,
  input  logic [$clog2(SIZE)-1:0] solver_y,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [1:0]              res_status,
  output logic [15:0]             res_steps,
  output logic [15:0]             res_cycles
);

  localparam int PW = $clog2(SIZE);
  localparam int IW = $clog2(SIZE + 1);
  localparam logic [IW-1:0] LAST_ROW  = IW'(SIZE - 1);
  localparam logic [3:0]    RST_LAST  = 4'(RST_CYCLES - 1);
  localparam logic [15:0]   MAX_C     = 16'(MAX_CYCLES);
  localparam logic [1:0]    ST_SOLVED = 2'b00;
  localparam logic [1:0]    ST_TMO    = 2'b01;
  localparam logic [1:0]    ST_ABORT  = 2'b10;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [IW-1:0]   row_idx_r, row_idx_s;
  logic [3:0]      rcnt_r, rcnt_s;
  logic [15:0]     cyc_r, cyc_s, cyc_inc_s;
  logic [15:0]     steps_r, steps_s, steps_inc_s;
  logic [2*PW-1:0] prev_r, prev_s;
  logic            first_r, first_s;
  logic            moved_s, timeout_s, row_accept_s, load_res_s;
  logic [1:0]      status_s;

  // Next-state, counter and result-capture decisions
  always_comb begin
    state_s      = state_r;
    row_idx_s    = row_idx_r;
    rcnt_s       = rcnt_r;
    cyc_s        = cyc_r;
    steps_s      = steps_r;
    prev_s       = prev_r;
    first_s      = first_r;
    row_accept_s = 1'b0;
    load_res_s   = 1'b0;
    status_s     = ST_SOLVED;
    cyc_inc_s    = cyc_r + 16'd1;
    // The very first RUN cycle only records where the solver starts
    moved_s      = !first_r && ({solver_x, solver_y} != prev_r);
    steps_inc_s  = (moved_s && (steps_r != 16'hFFFF)) ? steps_r + 16'd1 : steps_r;
    timeout_s    = (cyc_inc_s == MAX_C);
    case (state_r)
      LOAD: begin
        if (abort) begin
          row_idx_s = '0;
        end else if (row_valid && row_ready) begin
          row_accept_s = 1'b1;
          if (row_idx_r == LAST_ROW) begin
            row_idx_s = '0;
            state_s   = START;
            rcnt_s    = 4'd0;
            cyc_s     = 16'd0;
            steps_s   = 16'd0;
            prev_s    = '0;
            first_s   = 1'b1;
          end else begin
            row_idx_s = row_idx_r + IW'(1);
          end
        end else begin
          row_idx_s = row_idx_r;
        end
      end
      START: begin
        if (abort) begin
          state_s    = REPORT;
          load_res_s = 1'b1;
          status_s   = ST_ABORT;
        end else if (rcnt_r == RST_LAST) begin
          state_s = RUN;
        end else begin
          rcnt_s = rcnt_r + 4'd1;
        end
      end
      RUN: begin
        cyc_s   = cyc_inc_s;
        steps_s = steps_inc_s;
        prev_s  = {solver_x, solver_y};
        first_s = 1'b0;
        if (abort) begin
          state_s    = REPORT;
          load_res_s = 1'b1;
          status_s   = ST_ABORT;
        end else if (solver_done) begin
          state_s    = REPORT;
          load_res_s = 1'b1;
          status_s   = ST_SOLVED;
        end else if (timeout_s) begin
          state_s    = REPORT;
          load_res_s = 1'b1;
          status_s   = ST_TMO;
        end else begin
          state_s = RUN;
        end
      end
      REPORT: begin
        if (res_valid && res_ready) begin
          state_s = LOAD;
        end else begin
          state_s = REPORT;
        end
      end
      default: begin
        state_s = LOAD;
      end
    endcase
  end

  // State, counters and handshake outputs registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= LOAD;
      row_idx_r  <= '0;
      rcnt_r     <= 4'd0;
      cyc_r      <= 16'd0;
      steps_r    <= 16'd0;
      prev_r     <= '0;
      first_r    <= 1'b1;
      row_ready  <= 1'b1;
      solver_rst <= 1'b1;
      res_valid  <= 1'b0;
    end else begin
      state_r    <= state_s;
      row_idx_r  <= row_idx_s;
      rcnt_r     <= rcnt_s;
      cyc_r      <= cyc_s;
      steps_r    <= steps_s;
      prev_r     <= prev_s;
      first_r    <= first_s;
      row_ready  <= (state_s == LOAD);
      solver_rst <= (state_s != RUN);
      res_valid  <= (state_s == REPORT);
    end
  end

  // Maze storage and result latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maze_flat  <= '1;
      res_status <= 2'b00;
      res_steps  <= 16'd0;
      res_cycles <= 16'd0;
    end else begin
      if (row_accept_s) begin
        maze_flat[int'(row_idx_r)*SIZE +: SIZE] <= row_data;
      end
      if (load_res_s) begin
        res_status <= status_s;
        res_steps  <= steps_s;
        res_cycles <= cyc_s;
      end
    end
  end

endmodule

// File: tb/tb_maze_job_ctrl.sv
// Directed bench for maze_job_ctrl: default-budget instance "a" and a
// MAX_CYCLES=16 instance "b" share all inputs.
module tb_maze_job_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        row_valid = 1'b0;
  logic [8:0]  row_data = 9'd0;
  logic        abort = 1'b0;
  logic        solver_done = 1'b0;
  logic [3:0]  solver_x = 4'd0;
  logic [3:0]  solver_y = 4'd0;
  logic        res_ready = 1'b0;

  logic        a_row_ready, a_solver_rst, a_res_valid;
  logic [80:0] a_maze;
  logic [1:0]  a_status;
  logic [15:0] a_steps, a_cycles;
  logic        b_row_ready, b_solver_rst, b_res_valid;
  logic [80:0] b_maze;
  logic [1:0]  b_status;
  logic [15:0] b_steps, b_cycles;

  logic [80:0] exp_maze;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  maze_job_ctrl #(.SIZE(9), .MAX_CYCLES(1023), .RST_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .row_valid(row_valid), .row_data(row_data),
    .row_ready(a_row_ready), .abort(abort), .maze_flat(a_maze),
    .solver_rst(a_solver_rst), .solver_done(solver_done), .solver_x(solver_x),
    .solver_y(solver_y), .res_valid(a_res_valid), .res_ready(res_ready),
    .res_status(a_status), .res_steps(a_steps), .res_cycles(a_cycles));

  maze_job_ctrl #(.SIZE(9), .MAX_CYCLES(16), .RST_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .row_valid(row_valid), .row_data(row_data),
    .row_ready(b_row_ready), .abort(abort), .maze_flat(b_maze),
    .solver_rst(b_solver_rst), .solver_done(solver_done), .solver_x(solver_x),
    .solver_y(solver_y), .res_valid(b_res_valid), .res_ready(res_ready),
    .res_status(b_status), .res_steps(b_steps), .res_cycles(b_cycles));

  function automatic logic [8:0] row_pat(input int base, input int i);
    logic [8:0] one;
    one = 9'd1;
    return 9'(base) ^ (one << i);
  endfunction

  task automatic do_reset();
    row_valid = 1'b0; abort = 1'b0; solver_done = 1'b0; res_ready = 1'b0;
    solver_x = 4'd0; solver_y = 4'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic load_rows(input int base);
    for (int i = 0; i < 9; i++) begin
      row_valid = 1'b1;
      row_data  = row_pat(base, i);
      exp_maze[i*9 +: 9] = row_pat(base, i);
      @(posedge clk); #1;
    end
    row_valid = 1'b0;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (a_solver_rst && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (a_solver_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_run: solver_rst still %b after %0d cycles, required 0", a_solver_rst, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (a_row_ready !== 1'b1) begin n_fail++; $display("FAIL reset_row_ready: got %b exp 1", a_row_ready); end
    n_checks++; if (a_solver_rst !== 1'b1) begin n_fail++; $display("FAIL reset_solver_rst: got %b exp 1", a_solver_rst); end
    n_checks++; if (a_res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b exp 0", a_res_valid); end
    n_checks++; if (a_maze !== {81{1'b1}}) begin n_fail++; $display("FAIL reset_maze: got %h exp all ones", a_maze); end
    n_checks++; if ({a_status, a_steps, a_cycles} !== 34'd0) begin n_fail++; $display("FAIL reset_result: got %b/%0d/%0d exp 0/0/0", a_status, a_steps, a_cycles); end
  endtask

  task automatic test_solved();
    int n;
    do_reset();
    load_rows(9'h1FF);
    n_checks++; if (a_maze !== exp_maze) begin n_fail++; $display("FAIL solved_maze: got %h exp %h", a_maze, exp_maze); end
    n_checks++; if (a_row_ready !== 1'b0) begin n_fail++; $display("FAIL solved_row_ready_start: got %b exp 0", a_row_ready); end
    wait_run(n);
    n_checks++; if (n != 2) begin n_fail++; $display("FAIL solved_rst_pulse: got %0d cycles exp 2", n); end
    for (int k = 1; k <= 20; k++) begin
      solver_x = 4'(k); solver_y = 4'd0;
      solver_done = (k == 20);
      n_checks++; if (a_res_valid !== 1'b0) begin n_fail++; $display("FAIL solved_early_valid: got %b exp 0 at run cycle %0d", a_res_valid, k); end
      @(posedge clk); #1;
    end
    solver_done = 1'b0;
    n_checks++; if (a_res_valid !== 1'b1) begin n_fail++; $display("FAIL solved_valid: got %b exp 1", a_res_valid); end
    n_checks++; if (a_status !== 2'b00) begin n_fail++; $display("FAIL solved_status: got %b exp 00", a_status); end
    n_checks++; if (a_steps !== 16'd19) begin n_fail++; $display("FAIL solved_steps: got %0d exp 19", a_steps); end
    n_checks++; if (a_cycles !== 16'd20) begin n_fail++; $display("FAIL solved_cycles: got %0d exp 20", a_cycles); end
    n_checks++; if (a_solver_rst !== 1'b1) begin n_fail++; $display("FAIL solved_report_rst: got %b exp 1", a_solver_rst); end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    n_checks++; if (a_res_valid !== 1'b0) begin n_fail++; $display("FAIL solved_handshake_valid: got %b exp 0", a_res_valid); end
    n_checks++; if (a_row_ready !== 1'b1) begin n_fail++; $display("FAIL solved_handshake_ready: got %b exp 1", a_row_ready); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    load_rows(9'h000);
    wait_run(n);
    n = 0;
    while (!b_res_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++; if (n != 16) begin n_fail++; $display("FAIL timeout_latency: got %0d run cycles exp 16", n); end
    n_checks++; if (b_status !== 2'b01) begin n_fail++; $display("FAIL timeout_status: got %b exp 01", b_status); end
    n_checks++; if (b_cycles !== 16'd16) begin n_fail++; $display("FAIL timeout_cycles: got %0d exp 16", b_cycles); end
    n_checks++; if (b_steps !== 16'd0) begin n_fail++; $display("FAIL timeout_steps: got %0d exp 0", b_steps); end
    n_checks++; if (a_res_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_a_valid: got %b exp 0", a_res_valid); end
  endtask

  task automatic test_done_at_limit();
    int n;
    do_reset();
    load_rows(9'h0AA);
    wait_run(n);
    repeat (15) begin @(posedge clk); #1; end
    solver_done = 1'b1;
    @(posedge clk); #1;
    solver_done = 1'b0;
    n_checks++; if ({b_res_valid, b_status} !== 3'b100) begin n_fail++; $display("FAIL limit_b_status: got valid %b status %b exp 1/00", b_res_valid, b_status); end
    n_checks++; if (b_cycles !== 16'd16) begin n_fail++; $display("FAIL limit_b_cycles: got %0d exp 16", b_cycles); end
    n_checks++; if ({a_res_valid, a_status} !== 3'b100) begin n_fail++; $display("FAIL limit_a_status: got valid %b status %b exp 1/00", a_res_valid, a_status); end
  endtask

  task automatic test_abort();
    int n;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      row_valid = 1'b1; row_data = row_pat(9'h0F0, i);
      @(posedge clk); #1;
    end
    abort = 1'b1; row_data = 9'h0AA;
    @(posedge clk); #1;
    abort = 1'b0; row_valid = 1'b0;
    n_checks++; if ({a_row_ready, a_res_valid} !== 2'b10) begin n_fail++; $display("FAIL abort_load_flags: got ready %b valid %b exp 1/0", a_row_ready, a_res_valid); end
    load_rows(9'h133);
    n_checks++; if (a_maze !== exp_maze) begin n_fail++; $display("FAIL abort_reload_maze: got %h exp %h", a_maze, exp_maze); end
    n_checks++; if (a_res_valid !== 1'b0) begin n_fail++; $display("FAIL abort_load_no_result: got %b exp 0", a_res_valid); end
    wait_run(n);
    repeat (3) begin @(posedge clk); #1; end
    abort = 1'b1; solver_done = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; solver_done = 1'b0;
    n_checks++; if ({a_res_valid, a_status} !== 3'b110) begin n_fail++; $display("FAIL abort_run_status: got valid %b status %b exp 1/10", a_res_valid, a_status); end
    n_checks++; if (a_cycles !== 16'd4) begin n_fail++; $display("FAIL abort_run_cycles: got %0d exp 4", a_cycles); end
  endtask

  task automatic test_hold();
    int n;
    do_reset();
    load_rows(9'h055);
    wait_run(n);
    for (int k = 1; k <= 5; k++) begin
      solver_x = 4'd0; solver_y = 4'(k);
      solver_done = (k == 5);
      @(posedge clk); #1;
    end
    solver_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      abort = c[0];
      solver_x = 4'(c); solver_done = c[1];
      n_checks++;
      if ({a_res_valid, a_row_ready, a_status, a_steps, a_cycles} !== {1'b1, 1'b0, 2'b00, 16'd4, 16'd5}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got valid %b ready %b status %b steps %0d cycles %0d exp 1/0/00/4/5",
                 c, a_res_valid, a_row_ready, a_status, a_steps, a_cycles);
      end
      @(posedge clk); #1;
    end
    abort = 1'b0; solver_done = 1'b0;
  endtask

  task automatic test_rst_run();
    int n;
    do_reset();
    load_rows(9'h1F0);
    wait_run(n);
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (a_maze !== exp_maze) begin n_fail++; $display("FAIL rstrun_maze_before: got %h exp %h", a_maze, exp_maze); end
    rst = 1'b1;
    #1;
    n_checks++; if (a_solver_rst !== 1'b1) begin n_fail++; $display("FAIL rstrun_solver_rst: got %b exp 1", a_solver_rst); end
    n_checks++; if (a_res_valid !== 1'b0) begin n_fail++; $display("FAIL rstrun_res_valid: got %b exp 0", a_res_valid); end
    n_checks++; if (a_maze !== {81{1'b1}}) begin n_fail++; $display("FAIL rstrun_maze: got %h exp all ones", a_maze); end
    n_checks++; if (a_row_ready !== 1'b1) begin n_fail++; $display("FAIL rstrun_row_ready: got %b exp 1", a_row_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    n_checks++; if ({a_res_valid, a_row_ready, b_res_valid} !== 3'b010) begin n_fail++; $display("FAIL rstrun_no_result: got a_valid %b a_ready %b b_valid %b exp 0/1/0", a_res_valid, a_row_ready, b_res_valid); end
  endtask

  initial begin
    exp_maze = {81{1'b1}};
    test_reset();
    test_solved();
    test_timeout();
    test_done_at_limit();
    test_abort();
    test_hold();
    test_rst_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
